alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, registered successor to the team's 4-bit combinational ALU. It keeps the same 16-operation select encoding (sel[3]=0 arithmetic, sel[3]=1 logical) but generalises operand width, registers the result behind a valid/ready handshake, and adds an accumulator operand path. It sits between the operand/sequencer logic and the result bus of the datapath.

## Interface
- WIDTH, 4, operand width in bits; result is WIDTH+1 bits (WIDTH ≥ 2).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand/op beat is valid.
- in_ready  output  1  block accepts a beat this cycle.
- sel  input  4  operation select.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- use_acc  input  1  replace A with the accumulator for this beat.
- out_valid  output  1  y (and flags) are valid.
- out_ready  input  1  consumer takes the result this cycle.
- y  output  WIDTH+1  result.
- zf, nf, of  output  1 each  zero, negative and overflow flags (present only with ALU_FLAGS_EN).

## Operation
- Operand A is `use_acc ? acc : a`. acc is a WIDTH-bit register holding y[WIDTH-1:0] of the last accepted beat.
- Arithmetic ops (sel[3]=0): operands are sign-extended to WIDTH+1 bits, and the result is taken modulo 2^(WIDTH+1).
  - 000 A+1, 001 A−1, 010 B, 011 B+1, 100 B−1, 101 A, 110 A+B, 111 A<<1 (the extended value shifted, LSB 0).
- Logical ops (sel[3]=1): operands are zero-extended to WIDTH+1 bits and the op is applied over all WIDTH+1 bits, so inversions set y[WIDTH]=1.
  - 000 ~A, 001 ~B, 010 A&B, 011 A|B, 100 A^B, 101 ~(A^B), 110 ~(A&B), 111 ~(A|B).
- Beat accepted when in_valid && in_ready. The result is registered into y and out_valid is set on the same edge.
- in_ready = !out_valid || out_ready (single output register, full throughput).
- y and out_valid hold stable while out_valid && !out_ready. Inputs are ignored while in_ready=0.
- Accept and drain in the same cycle: y is replaced by the new result and out_valid stays 1.
- Drain with no accept: out_valid clears and y holds its last value.
- acc updates only on accept. use_acc uses the acc value from before that edge.

## Timing
- Reset values: out_valid=0, y=0, acc=0, zf=0, nf=0, of=0. in_ready=1 while in reset.
- Latency is 1 cycle from accept edge to out_valid=1. Throughput is 1 beat/cycle with out_ready held high.
- Reset asserted mid-transfer discards the pending result immediately (asynchronous). After release the first accepted beat sees acc=0.
- There are no combinational paths from in_valid, a, b or sel to any output. in_ready depends combinationally on out_ready only.

## Configuration
- ALU_FLAGS_EN defined: zf, nf and of ports exist and are registered alongside y with the same enable.
  - zf = (y==0).
  - nf = y[WIDTH].
  - of = arithmetic op && (y[WIDTH] != y[WIDTH-1]), meaning the result does not fit in WIDTH signed bits. of=0 for logical ops.
- ALU_FLAGS_EN undefined: flag ports and flag registers are absent. All other behaviour is identical.

## Structure
- Package alu_pkg holds:
  - the 4-bit op encoding constants (OP_INC_A … OP_SHL_A, OP_NOT_A … OP_NOR);
  - an op-class helper: is_arith = ~sel[3].
- Sub-module alu_core: purely combinational (WIDTH, sel, A, B → result and raw flags).
- alu_pipe owns the handshake, the output register and acc.

## Test plan
- WIDTH=4, sel=0110, a=0111, b=0001, out_ready=1 → one cycle later y=01000, out_valid=1; with flags, of=1, nf=0.
- sel=1000, a=0101 → y=11010. sel=1010, a=1100, b=1010 → y=01000. Both give of=0.
- sel=0001, a=1000 → y=10111 (−9), nf=1, of=1. sel=0111, a=0110 → y=01100, of=1.
- Backpressure: accept beat X (a=0011, b=0010, sel=0110) with out_ready=0 → y=00101 held and in_ready=0 for 3 cycles; beat Y is presented but not taken. Then out_ready=1 → Y accepted that cycle and its result appears the next cycle.
- Accumulator chain: a=0010, sel=0000 (y=00011, acc=0011); then use_acc=1, sel=0110, b=0001 → y=00100; then use_acc=1, sel=0111 → y=01000.
- Reset: assert rst_n=0 while out_valid=1 and out_ready=0 → out_valid, y and acc are 0 immediately. After release, use_acc=1, sel=0000 → y=00001.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op encoding and op-class helper for the pipelined ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_INC_A  = 4'b0000,
    OP_DEC_A  = 4'b0001,
    OP_PASS_B = 4'b0010,
    OP_INC_B  = 4'b0011,
    OP_DEC_B  = 4'b0100,
    OP_PASS_A = 4'b0101,
    OP_ADD    = 4'b0110,
    OP_SHL_A  = 4'b0111,
    OP_NOT_A  = 4'b1000,
    OP_NOT_B  = 4'b1001,
    OP_AND    = 4'b1010,
    OP_OR     = 4'b1011,
    OP_XOR    = 4'b1100,
    OP_XNOR   = 4'b1101,
    OP_NAND   = 4'b1110,
    OP_NOR    = 4'b1111
  } alu_op_e;

  function automatic logic is_arith(input logic [3:0] sel);
    return ~sel[3];
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: WIDTH+1-bit result, 0 latency, no flow control.
// Raw zf/nf/of outputs exist only when ALU_FLAGS_EN is defined.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALU_FLAGS_EN
  output logic             zf,
  output logic             nf,
  output logic             of,
`endif
  output logic [WIDTH:0]   y
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] sa, sb, za, zb;

  // Arithmetic works on sign-extended operands, logic on zero-extended ones.
  assign sa = {a[WIDTH-1], a};
  assign sb = {b[WIDTH-1], b};
  assign za = {1'b0, a};
  assign zb = {1'b0, b};

  always_comb begin
    y = '0;
    case (sel)
      OP_INC_A:  y = sa + ONE;
      OP_DEC_A:  y = sa - ONE;
      OP_PASS_B: y = sb;
      OP_INC_B:  y = sb + ONE;
      OP_DEC_B:  y = sb - ONE;
      OP_PASS_A: y = sa;
      OP_ADD:    y = sa + sb;
      OP_SHL_A:  y = {sa[WIDTH-1:0], 1'b0};
      OP_NOT_A:  y = ~za;
      OP_NOT_B:  y = ~zb;
      OP_AND:    y = za & zb;
      OP_OR:     y = za | zb;
      OP_XOR:    y = za ^ zb;
      OP_XNOR:   y = ~(za ^ zb);
      OP_NAND:   y = ~(za & zb);
      OP_NOR:    y = ~(za | zb);
      default:   y = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  assign zf = (y == '0);
  assign nf = y[WIDTH];
  assign of = is_arith(sel) && (y[WIDTH] != y[WIDTH-1]);
`endif

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with accumulator operand: 1-cycle latency, 1 beat/cycle; result
// holds under backpressure (in_ready = !out_valid || out_ready). Flags need ALU_FLAGS_EN.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef ALU_FLAGS_EN
  output logic             zf,
  output logic             nf,
  output logic             of,
`endif
  output logic [WIDTH:0]   y
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH:0]   res;
  logic             accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign op_a     = use_acc ? acc : a;

`ifdef ALU_FLAGS_EN
  logic res_zf, res_nf, res_of;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .sel (sel),
    .a   (op_a),
    .b   (b),
`ifdef ALU_FLAGS_EN
    .zf  (res_zf),
    .nf  (res_nf),
    .of  (res_of),
`endif
    .y   (res)
  );

  // Drain without a new beat only drops out_valid; y keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      acc       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= res;
      acc       <= res[WIDTH-1:0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf <= 1'b0;
      nf <= 1'b0;
      of <= 1'b0;
    end else if (accept) begin
      zf <= res_zf;
      nf <= res_nf;
      of <= res_of;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed plan vectors, backpressure, accumulator,
// mid-transfer reset and a random phase. Flag checks compile in with ALU_FLAGS_EN.
module tb_alu_pipe;
  localparam int W = 4;

  typedef struct {
    logic [W:0] y;
    logic [3:0] sel;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [3:0]   sel;
  logic [W-1:0] a, b;
  logic         use_acc;
  logic         out_valid, out_ready;
  logic [W:0]   y;
`ifdef ALU_FLAGS_EN
  logic         zf, nf, of;
`endif

  int n_vec = 0;
  int n_err = 0;

  exp_t         sb_q[$];
  logic [W-1:0] m_acc = '0;
  logic         dir_vld = 1'b0;
  logic [W:0]   dir_y = '0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ALU_FLAGS_EN
    .zf        (zf),
    .nf        (nf),
    .of        (of),
`endif
    .y         (y)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic reduced mod 2^(W+1), bitwise ops on W+1 bits.
  function automatic logic [W:0] model(input logic [3:0] s, input logic [W-1:0] ao,
                                       input logic [W-1:0] bo);
    int sa, sb, r;
    logic [W:0] za, zb, lr;
    sa = int'(ao);
    if (ao[W-1]) sa = sa - (1 << W);
    sb = int'(bo);
    if (bo[W-1]) sb = sb - (1 << W);
    za = {1'b0, ao};
    zb = {1'b0, bo};
    if (!s[3]) begin
      case (s[2:0])
        3'd0:    r = sa + 1;
        3'd1:    r = sa - 1;
        3'd2:    r = sb;
        3'd3:    r = sb + 1;
        3'd4:    r = sb - 1;
        3'd5:    r = sa;
        3'd6:    r = sa + sb;
        default: r = sa * 2;
      endcase
      return r[W:0];
    end
    case (s[2:0])
      3'd0:    lr = ~za;
      3'd1:    lr = ~zb;
      3'd2:    lr = za & zb;
      3'd3:    lr = za | zb;
      3'd4:    lr = za ^ zb;
      3'd5:    lr = ~(za ^ zb);
      3'd6:    lr = ~(za & zb);
      default: lr = ~(za | zb);
    endcase
    return lr;
  endfunction

  // Scoreboard: pop on consume, then push on accept (both resolved at the next rising edge).
  always @(negedge clk) begin
    exp_t e;
    logic [W-1:0] opa;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        check_val("sb_depth", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_val("y", 32'(y), 32'(e.y));
`ifdef ALU_FLAGS_EN
          check_val("zf", 32'(zf), 32'(e.y == '0));
          check_val("nf", 32'(nf), 32'(e.y[W]));
          check_val("of", 32'(of), 32'(!e.sel[3] && (e.y[W] != e.y[W-1])));
`endif
        end
      end
      if (in_valid && in_ready) begin
        opa   = use_acc ? m_acc : a;
        e.sel = sel;
        e.y   = dir_vld ? dir_y : model(sel, opa, b);
        sb_q.push_back(e);
        m_acc = e.y[W-1:0];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] s, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ua, input logic [W:0] ey);
    in_valid  = 1'b1;
    sel       = s;
    a         = av;
    b         = bv;
    use_acc   = ua;
    out_ready = 1'b1;
    dir_vld   = 1'b1;
    dir_y     = ey;
    step();
    in_valid  = 1'b0;
    dir_vld   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sel = '0; a = '0; b = '0; use_acc = 1'b0; out_ready = 1'b1;
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_y", 32'(y), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_FLAGS_EN
    check_val("rst_flags", 32'({zf, nf, of}), 32'd0);
`endif
    step(); step();
    rst_n = 1'b1;
    step();

    // Plan vectors, back to back
    beat(4'b0110, 4'b0111, 4'b0001, 1'b0, 5'b01000);
    check_val("latency_vld", 32'(out_valid), 32'd1);
    beat(4'b1000, 4'b0101, 4'b0000, 1'b0, 5'b11010);
    beat(4'b1010, 4'b1100, 4'b1010, 1'b0, 5'b01000);
    beat(4'b0001, 4'b1000, 4'b0000, 1'b0, 5'b10111);
    beat(4'b0111, 4'b0110, 4'b0000, 1'b0, 5'b01100);
    step();
    check_val("drain_vld", 32'(out_valid), 32'd0);
    check_val("drain_y_hold", 32'(y), 32'b01100);

    // Backpressure: X accepted with out_ready low, Y waits three cycles
    in_valid = 1'b1; sel = 4'b0110; a = 4'b0011; b = 4'b0010; use_acc = 1'b0;
    out_ready = 1'b0; dir_vld = 1'b1; dir_y = 5'b00101;
    step();
    sel = 4'b1011; a = 4'b0001; b = 4'b0100; dir_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      check_val("bp_y_hold", 32'(y), 32'b00101);
      check_val("bp_vld_hold", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_release_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_val("bp_y_next", 32'(y), 32'b00101);
    step();

    // Accumulator chain
    beat(4'b0000, 4'b0010, 4'b0000, 1'b0, 5'b00011);
    beat(4'b0110, 4'b0000, 4'b0001, 1'b1, 5'b00100);
    beat(4'b0111, 4'b0000, 4'b0000, 1'b1, 5'b01000);
    step();

    // Reset while a result is stalled
    in_valid = 1'b1; sel = 4'b0110; a = 4'b0101; b = 4'b0001; use_acc = 1'b0; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check_val("pre_rst_vld", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_vld", 32'(out_valid), 32'd0);
    check_val("midrst_y", 32'(y), 32'd0);
    check_val("midrst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    m_acc = '0;
    step();
    rst_n = 1'b1;
    step();
    beat(4'b0000, 4'b1111, 4'b0000, 1'b1, 5'b00001);
    step();

    // Random traffic with random backpressure and accumulator use
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      sel       = 4'($urandom_range(0, 15));
      a         = W'($urandom_range(0, (1 << W) - 1));
      b         = W'($urandom_range(0, (1 << W) - 1));
      use_acc   = 1'($urandom_range(0, 1));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(); step();
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    check_val("final_vld", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
